bank_ch_resp_router: RTL and testbench

// - Return path of the crossbar bank port: routes in-order bank responses back to one of 3 requesting channels.
// - Bank-side round-robin arbiter grants a channel; each accepted grant pushes its channel ID into an order FIFO.
// - Each bank response pops the FIFO head and is delivered to that channel through a 1-entry output register (valid/ready).
// - Sits between bank response output and the per-channel response ports.

---
 rtl/xbar_pkg.sv | 19 +
 rtl/xbar_id_fifo.sv | 49 ++++
 rtl/bank_ch_resp_router.sv | 90 +++++++++
 tb/tb_bank_ch_resp_router.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: channel count, channel ID type and ID decode helper.
package xbar_pkg;

  localparam int CH_NUM  = 3;
  localparam int CH_ID_W = 2;

  typedef logic [CH_ID_W-1:0] ch_id_t;

  // IDs outside 0..CH_NUM-1 decode to all zeros.
  function automatic logic [CH_NUM-1:0] ch_id_to_onehot(input ch_id_t id);
    logic [CH_NUM-1:0] oh;
    oh = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (id == ch_id_t'(k)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/xbar_id_fifo.sv
// Small synchronous FIFO with wrap-bit pointers, used to remember request order
// (channel IDs) so responses can be steered back in the same order.
module xbar_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Full when the pointers address the same slot but sit on different laps.
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];
  assign count   = CNT_W'(wptr - rptr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bank_ch_resp_router.sv
// Bank-port return path: steers in-order bank responses to the channel that
// issued the matching grant, through a single valid/ready output stage.
module bank_ch_resp_router
  import xbar_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        gnt_valid_i,
  input  ch_id_t                      gnt_id_i,
  output logic                        gnt_ready_o,
  input  logic                        bank_resp_valid_i,
  input  logic [DATA_W-1:0]           bank_resp_data_i,
  output logic                        bank_resp_ready_o,
  output logic [CH_NUM-1:0]           ch_resp_valid_o,
  output logic [DATA_W-1:0]           ch_resp_data_o,
  input  logic [CH_NUM-1:0]           ch_resp_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]  outstanding_o,
  output logic                        err_o
);

  ch_id_t              head_id;
  ch_id_t              out_id;
  logic                out_vld;
  logic [DATA_W-1:0]   out_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                out_retire;
  logic                out_free;
  logic                gnt_bad;
  logic                resp_bad;
  logic                err_q;

  xbar_id_fifo #(
    .W     (CH_ID_W),
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (gnt_id_i),
    .pop       (pop),
    .head      (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding_o)
  );

  assign gnt_ready_o = !fifo_full;
  assign push        = gnt_valid_i && !fifo_full && (gnt_id_i < ch_id_t'(CH_NUM));

  // Only the ready of the channel currently being served matters.
  assign out_retire        = out_vld && (|(ch_id_to_onehot(out_id) & ch_resp_ready_i));
  assign out_free          = !out_vld || out_retire;
  assign bank_resp_ready_o = !fifo_empty && out_free;
  assign pop               = bank_resp_valid_i && bank_resp_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld  <= 1'b0;
      out_id   <= '0;
      out_data <= '0;
    end else if (pop) begin
      out_vld  <= 1'b1;
      out_id   <= head_id;
      out_data <= bank_resp_data_i;
    end else if (out_retire) begin
      out_vld  <= 1'b0;
    end
  end

  assign ch_resp_valid_o = out_vld ? ch_id_to_onehot(out_id) : '0;
  assign ch_resp_data_o  = out_data;

  // Illegal grant ID, grant into a full FIFO, or a response nobody asked for.
  assign gnt_bad  = gnt_valid_i && (fifo_full || (gnt_id_i >= ch_id_t'(CH_NUM)));
  assign resp_bad = bank_resp_valid_i && fifo_empty && !out_vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_q | gnt_bad | resp_bad;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_bank_ch_resp_router.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_bank_ch_resp_router;
  import xbar_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              gnt_valid_i;
  logic [1:0]        gnt_id_i;
  logic              gnt_ready_o;
  logic              bank_resp_valid_i;
  logic [DATA_W-1:0] bank_resp_data_i;
  logic              bank_resp_ready_o;
  logic [2:0]        ch_resp_valid_o;
  logic [DATA_W-1:0] ch_resp_data_o;
  logic [2:0]        ch_resp_ready_i;
  logic [CNT_W-1:0]  outstanding_o;
  logic              err_o;

  bank_ch_resp_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .gnt_valid_i       (gnt_valid_i),
    .gnt_id_i          (gnt_id_i),
    .gnt_ready_o       (gnt_ready_o),
    .bank_resp_valid_i (bank_resp_valid_i),
    .bank_resp_data_i  (bank_resp_data_i),
    .bank_resp_ready_o (bank_resp_ready_o),
    .ch_resp_valid_o   (ch_resp_valid_o),
    .ch_resp_data_o    (ch_resp_data_o),
    .ch_resp_ready_i   (ch_resp_ready_i),
    .outstanding_o     (outstanding_o),
    .err_o             (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic              gv;
    logic [1:0]        gid;
    logic              rv;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        chr;
    logic              e_gready;
    logic              e_bready;
    logic [2:0]        e_valid;
    logic [DATA_W-1:0] e_data;
    logic [CNT_W-1:0]  e_out;
    logic              e_err;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: pending channel IDs in request order plus the held response.
  int          mq[$];
  bit          m_vld;
  int          m_id;
  logic [31:0] m_data;
  bit          m_err;

  function automatic vec_t mkVec(logic gv, logic [1:0] gid, logic rv, logic [31:0] rdata,
                                 logic [2:0] chr, logic eg, logic eb, logic [2:0] ev,
                                 logic [31:0] ed, logic [CNT_W-1:0] eo, logic ee);
    vec_t v;
    v.gv = gv; v.gid = gid; v.rv = rv; v.rdata = rdata; v.chr = chr;
    v.e_gready = eg; v.e_bready = eb; v.e_valid = ev; v.e_data = ed; v.e_out = eo; v.e_err = ee;
    return v;
  endfunction

  function automatic vec_t mkIn(logic gv, logic [1:0] gid, logic rv, logic [31:0] rdata, logic [2:0] chr);
    return mkVec(gv, gid, rv, rdata, chr, 1'b0, 1'b0, 3'b000, 32'h0, '0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput(input string tag);
    bit full;
    bit free;
    full = (mq.size() == DEPTH);
    free = !m_vld || ch_resp_ready_i[m_id];
    check({tag, " gnt_ready"}, 32'(gnt_ready_o), 32'(!full));
    check({tag, " bank_ready"}, 32'(bank_resp_ready_o), 32'((mq.size() != 0) && free));
    check({tag, " ch_valid"}, 32'(ch_resp_valid_o), m_vld ? (32'd1 << m_id) : 32'd0);
    check({tag, " ch_data"}, ch_resp_data_o, m_data);
    check({tag, " outstanding"}, 32'(outstanding_o), 32'(mq.size()));
    check({tag, " err"}, 32'(err_o), 32'(m_err));
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, " rst gnt_ready"}, 32'(gnt_ready_o), 32'd1);
    check({tag, " rst bank_ready"}, 32'(bank_resp_ready_o), 32'd0);
    check({tag, " rst ch_valid"}, 32'(ch_resp_valid_o), 32'd0);
    check({tag, " rst ch_data"}, ch_resp_data_o, 32'd0);
    check({tag, " rst outstanding"}, 32'(outstanding_o), 32'd0);
    check({tag, " rst err"}, 32'(err_o), 32'd0);
  endtask

  task automatic modelReset();
    mq.delete();
    m_vld  = 1'b0;
    m_id   = 0;
    m_data = '0;
    m_err  = 1'b0;
  endtask

  task automatic modelStep();
    bit full;
    bit bready;
    full   = (mq.size() == DEPTH);
    bready = (mq.size() != 0) && (!m_vld || ch_resp_ready_i[m_id]);
    if (gnt_valid_i && (full || gnt_id_i == 2'd3)) m_err = 1'b1;
    if (bank_resp_valid_i && mq.size() == 0 && !m_vld) m_err = 1'b1;
    if (bank_resp_valid_i && bready) begin
      m_id   = mq.pop_front();
      m_vld  = 1'b1;
      m_data = bank_resp_data_i;
    end else if (m_vld && ch_resp_ready_i[m_id]) begin
      m_vld = 1'b0;
    end
    if (gnt_valid_i && !full && gnt_id_i != 2'd3) mq.push_back(int'(gnt_id_i));
  endtask

  task automatic driveIdle();
    gnt_valid_i       = 1'b0;
    gnt_id_i          = 2'd0;
    bank_resp_valid_i = 1'b0;
    bank_resp_data_i  = '0;
    ch_resp_ready_i   = 3'b111;
  endtask

  // Drive one cycle's inputs on the falling edge and check outputs just after.
  task automatic applyStimulus(input vec_t v, input bit useTable, input string tag);
    @(negedge clk_i);
    gnt_valid_i       = v.gv;
    gnt_id_i          = v.gid;
    bank_resp_valid_i = v.rv;
    bank_resp_data_i  = v.rdata;
    ch_resp_ready_i   = v.chr;
    #1;
    checkOutput(tag);
    if (useTable) begin
      check({tag, " tbl gnt_ready"}, 32'(gnt_ready_o), 32'(v.e_gready));
      check({tag, " tbl bank_ready"}, 32'(bank_resp_ready_o), 32'(v.e_bready));
      check({tag, " tbl ch_valid"}, 32'(ch_resp_valid_o), 32'(v.e_valid));
      check({tag, " tbl ch_data"}, ch_resp_data_o, v.e_data);
      check({tag, " tbl outstanding"}, 32'(outstanding_o), 32'(v.e_out));
      check({tag, " tbl err"}, 32'(err_o), 32'(v.e_err));
    end
  endtask

  task automatic finishCycle();
    @(posedge clk_i);
    modelStep();
  endtask

  // Asynchronous reset from wherever we are in the cycle.
  task automatic assertResetNow(input string tag);
    rst_i = 1'b1;
    driveIdle();
    modelReset();
    #1;
    checkResetValues(tag);
    @(negedge clk_i);
    rst_i = 1'b0;
    finishCycle();
  endtask

  task automatic doReset(input string tag);
    @(negedge clk_i);
    #2;
    assertResetNow(tag);
  endtask

  vec_t tbl[$];

  initial begin
    driveIdle();
    modelReset();
    rst_i = 1'b1;
    #1;
    checkResetValues("init");
    @(negedge clk_i);
    rst_i = 1'b0;
    finishCycle();

    // Single response, then four-deep ordering with full FIFO.
    tbl.push_back(mkVec(1, 2'd2, 0, 32'h0,         3'b111, 1, 0, 3'b000, 32'h0,         3'd0, 0));
    tbl.push_back(mkVec(0, 2'd0, 1, 32'hA5A5_0001, 3'b111, 1, 1, 3'b000, 32'h0,         3'd1, 0));
    tbl.push_back(mkVec(0, 2'd0, 0, 32'h0,         3'b111, 1, 0, 3'b100, 32'hA5A5_0001, 3'd0, 0));
    tbl.push_back(mkVec(0, 2'd0, 0, 32'h0,         3'b111, 1, 0, 3'b000, 32'hA5A5_0001, 3'd0, 0));
    tbl.push_back(mkVec(1, 2'd0, 0, 32'h0,         3'b111, 1, 0, 3'b000, 32'hA5A5_0001, 3'd0, 0));
    tbl.push_back(mkVec(1, 2'd1, 0, 32'h0,         3'b111, 1, 1, 3'b000, 32'hA5A5_0001, 3'd1, 0));
    tbl.push_back(mkVec(1, 2'd2, 0, 32'h0,         3'b111, 1, 1, 3'b000, 32'hA5A5_0001, 3'd2, 0));
    tbl.push_back(mkVec(1, 2'd0, 0, 32'h0,         3'b111, 1, 1, 3'b000, 32'hA5A5_0001, 3'd3, 0));
    tbl.push_back(mkVec(0, 2'd0, 1, 32'h1111_0000, 3'b111, 0, 1, 3'b000, 32'hA5A5_0001, 3'd4, 0));
    tbl.push_back(mkVec(0, 2'd0, 1, 32'h1111_0001, 3'b111, 1, 1, 3'b001, 32'h1111_0000, 3'd3, 0));
    tbl.push_back(mkVec(0, 2'd0, 1, 32'h1111_0002, 3'b111, 1, 1, 3'b010, 32'h1111_0001, 3'd2, 0));
    tbl.push_back(mkVec(0, 2'd0, 1, 32'h1111_0003, 3'b111, 1, 1, 3'b100, 32'h1111_0002, 3'd1, 0));
    tbl.push_back(mkVec(0, 2'd0, 0, 32'h0,         3'b111, 1, 0, 3'b001, 32'h1111_0003, 3'd0, 0));
    tbl.push_back(mkVec(0, 2'd0, 0, 32'h0,         3'b111, 1, 0, 3'b000, 32'h1111_0003, 3'd0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], 1'b1, $sformatf("vec%0d", i));
      finishCycle();
    end

    // Backpressure: channel 1 holds off for five cycles.
    doReset("bp");
    applyStimulus(mkVec(1, 2'd1, 0, 32'h0, 3'b111, 1, 0, 3'b000, 32'h0, 3'd0, 0), 1'b1, "bp0");
    finishCycle();
    applyStimulus(mkVec(1, 2'd2, 0, 32'h0, 3'b111, 1, 1, 3'b000, 32'h0, 3'd1, 0), 1'b1, "bp1");
    finishCycle();
    applyStimulus(mkVec(0, 2'd0, 1, 32'hB0B0_0001, 3'b101, 1, 1, 3'b000, 32'h0, 3'd2, 0), 1'b1, "bp2");
    finishCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mkVec(0, 2'd0, 1, 32'hB0B0_0002, 3'b101, 1, 0, 3'b010, 32'hB0B0_0001, 3'd1, 0),
                    1'b1, $sformatf("bp_stall%0d", i));
      finishCycle();
    end
    applyStimulus(mkVec(0, 2'd0, 1, 32'hB0B0_0002, 3'b111, 1, 1, 3'b010, 32'hB0B0_0001, 3'd1, 0), 1'b1, "bp_rel");
    finishCycle();
    applyStimulus(mkVec(0, 2'd0, 0, 32'h0, 3'b111, 1, 0, 3'b100, 32'hB0B0_0002, 3'd0, 0), 1'b1, "bp_next");
    finishCycle();

    // Wrap: grant and response every cycle keeps one entry outstanding.
    applyStimulus(mkIn(1, 2'd0, 0, 32'h0, 3'b111), 1'b0, "wrap_pre");
    finishCycle();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(mkIn(1, 2'((i + 1) % 3), 1, 32'hC000_0000 + 32'(i), 3'b111), 1'b0, $sformatf("wrap%0d", i));
      check($sformatf("wrap%0d out", i), 32'(outstanding_o), 32'd1);
      check($sformatf("wrap%0d err", i), 32'(err_o), 32'd0);
      check($sformatf("wrap%0d valid", i), 32'(ch_resp_valid_o),
            (i == 0) ? 32'd0 : (32'd1 << ((i - 1) % 3)));
      finishCycle();
    end
    applyStimulus(mkIn(0, 2'd0, 1, 32'hC000_00FF, 3'b111), 1'b0, "wrap_drain");
    finishCycle();
    applyStimulus(mkIn(0, 2'd0, 0, 32'h0, 3'b111), 1'b0, "wrap_idle");
    finishCycle();

    // Errors: illegal ID, response with nothing outstanding, grant while full.
    doReset("e_id");
    applyStimulus(mkIn(1, 2'd3, 0, 32'h0, 3'b111), 1'b0, "e_id3");
    finishCycle();
    applyStimulus(mkIn(0, 2'd0, 0, 32'h0, 3'b111), 1'b0, "e_id3_after");
    check("e_id3 out", 32'(outstanding_o), 32'd0);
    check("e_id3 err", 32'(err_o), 32'd1);
    finishCycle();
    doReset("e_empty");
    applyStimulus(mkIn(0, 2'd0, 1, 32'hDEAD_0000, 3'b111), 1'b0, "e_empty");
    check("e_empty bank_ready", 32'(bank_resp_ready_o), 32'd0);
    finishCycle();
    applyStimulus(mkIn(0, 2'd0, 0, 32'h0, 3'b111), 1'b0, "e_empty_after");
    check("e_empty err", 32'(err_o), 32'd1);
    finishCycle();
    doReset("e_full");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mkIn(1, 2'(i % 3), 0, 32'h0, 3'b111), 1'b0, $sformatf("e_fill%0d", i));
      finishCycle();
    end
    applyStimulus(mkIn(1, 2'd1, 0, 32'h0, 3'b111), 1'b0, "e_full_gnt");
    check("e_full gnt_ready", 32'(gnt_ready_o), 32'd0);
    finishCycle();
    applyStimulus(mkIn(0, 2'd0, 0, 32'h0, 3'b111), 1'b0, "e_full_after");
    check("e_full out", 32'(outstanding_o), 32'd4);
    check("e_full err", 32'(err_o), 32'd1);
    finishCycle();

    // Reset mid-stall with three entries still outstanding.
    doReset("rs");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mkIn(1, 2'(i % 3), 0, 32'h0, 3'b111), 1'b0, $sformatf("rs_fill%0d", i));
      finishCycle();
    end
    applyStimulus(mkIn(0, 2'd0, 1, 32'hE000_0000, 3'b110), 1'b0, "rs_pop");
    finishCycle();
    applyStimulus(mkIn(0, 2'd0, 1, 32'hE000_0001, 3'b110), 1'b0, "rs_stall");
    check("rs_stall valid", 32'(ch_resp_valid_o), 32'd1);
    check("rs_stall out", 32'(outstanding_o), 32'd3);
    finishCycle();
    #2;
    assertResetNow("rs_mid");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] gid;
      gid = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      applyStimulus(mkIn(1'($urandom_range(0, 1)), gid, 1'($urandom_range(0, 3) != 0),
                         32'($urandom), 3'($urandom_range(0, 7))), 1'b0, $sformatf("rnd%0d", i));
      finishCycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
